// File: rtl/jump_ctrl_if.sv
// Program-counter load bus between jump_ctrl and its surroundings.
// slave: pcc/instr/flag inputs in; load strobe, address, flags, stack status out.
interface jump_ctrl_if #(
  parameter int AW    = 8,
  parameter int OPW   = 7,
  parameter int DEPTH = 4
);
  localparam int SPW = $clog2(DEPTH) + 1;

  logic [AW-1:0]     pcc;
  logic [OPW+AW-1:0] instr;
  logic              flag_we;
  logic              z_in;
  logic              n_in;
  logic              c_in;
  logic              v_in;
  logic              l;
  logic [AW-1:0]     dataIM;
  logic [3:0]        flags;
  logic [SPW-1:0]    sp;
  logic              stk_ovf;
  logic              stk_unf;

  modport slave (
    input  pcc, instr, flag_we,
    input  z_in, n_in, c_in, v_in,
    output l, dataIM, flags,
    output sp, stk_ovf, stk_unf
  );

  modport master (
    output pcc, instr, flag_we,
    output z_in, n_in, c_in, v_in,
    input  l, dataIM, flags,
    input  sp, stk_ovf, stk_unf
  );
endinterface

// File: rtl/jump_ctrl.sv
// Jump/call/return control feeding the PC load strobe and load address.
// Ports: clk, rst (sync, active high), bus (jump_ctrl_if.slave).
module jump_ctrl #(
  parameter int AW        = 8,
  parameter int OPW       = 7,
  parameter int DEPTH     = 4,
  parameter int LAST_ADDR = 91
) (
  input logic        clk,
  input logic        rst,
  jump_ctrl_if.slave bus
);
  localparam int SPW = $clog2(DEPTH) + 1;
  localparam int IW  = $clog2(DEPTH);

  localparam logic [OPW-1:0] OP_JMP  = OPW'('h13);
  localparam logic [OPW-1:0] OP_JEQ  = OPW'('h14);
  localparam logic [OPW-1:0] OP_JNE  = OPW'('h15);
  localparam logic [OPW-1:0] OP_JGT  = OPW'('h16);
  localparam logic [OPW-1:0] OP_JLT  = OPW'('h17);
  localparam logic [OPW-1:0] OP_JGE  = OPW'('h18);
  localparam logic [OPW-1:0] OP_JLE  = OPW'('h19);
  localparam logic [OPW-1:0] OP_JCR  = OPW'('h1A);
  localparam logic [OPW-1:0] OP_JOV  = OPW'('h1B);
  localparam logic [OPW-1:0] OP_CALL = OPW'('h1C);
  localparam logic [OPW-1:0] OP_RET  = OPW'('h1D);

  logic [OPW-1:0] op;
  logic [AW-1:0]  lit;
  logic           z_q, n_q, c_q, v_q;
  logic [SPW-1:0] sp_q;
  logic [SPW-1:0] sp_dec;
  logic           ovf_q, unf_q;
  logic [AW-1:0]  stk [DEPTH];
  logic [AW-1:0]  ret_addr;
  logic           at_end;
  logic           full;
  logic           empty;
  logic           take;
  logic           is_call;
  logic           is_ret;
  logic           live;

  assign op       = bus.instr[AW+OPW-1:AW];
  assign lit      = bus.instr[AW-1:0];
  assign at_end   = bus.pcc == AW'(LAST_ADDR);
  assign full     = sp_q == SPW'(DEPTH);
  assign empty    = sp_q == '0;
  assign sp_dec   = sp_q - SPW'(1);
  assign ret_addr = stk[sp_dec[IW-1:0]];

  always_comb begin
    take    = 1'b0;
    is_call = 1'b0;
    is_ret  = 1'b0;
    unique case (1'b1)
      op == OP_JMP: take = 1'b1;
      op == OP_JEQ: take = z_q;
      op == OP_JNE: take = !z_q;
      op == OP_JGT: take = !z_q && (n_q == v_q);
      op == OP_JLT: take = n_q != v_q;
      op == OP_JGE: take = n_q == v_q;
      op == OP_JLE: take = z_q || (n_q != v_q);
      op == OP_JCR: take = c_q;
      op == OP_JOV: take = v_q;
      op == OP_CALL: begin
        take    = 1'b1;
        is_call = 1'b1;
      end
      op == OP_RET: begin
        take   = !empty;
        is_ret = 1'b1;
      end
      default: ;
    endcase
  end

  // At the last address the counter wraps on its own, so loads are masked.
  assign live = !rst && !at_end;

  assign bus.l      = live && take;
  assign bus.dataIM = !bus.l ? '0
                    : is_ret ? ret_addr : lit;

  always_ff @(posedge clk) begin
    if (rst) begin
      z_q   <= 1'b0;
      n_q   <= 1'b0;
      c_q   <= 1'b0;
      v_q   <= 1'b0;
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (bus.flag_we) begin
        z_q <= bus.z_in;
        n_q <= bus.n_in;
        c_q <= bus.c_in;
        v_q <= bus.v_in;
      end
      if (!at_end && is_call) begin
        if (full) begin
          ovf_q <= 1'b1;
        end else begin
          stk[sp_q[IW-1:0]] <= bus.pcc + AW'(1);
          sp_q              <= sp_q + SPW'(1);
        end
      end
      if (!at_end && is_ret) begin
        if (empty) unf_q <= 1'b1;
        else       sp_q  <= sp_dec;
      end
    end
  end

  assign bus.flags   = {z_q, n_q, c_q, v_q};
  assign bus.sp      = sp_q;
  assign bus.stk_ovf = ovf_q;
  assign bus.stk_unf = unf_q;
endmodule

// File: tb/tb_jump_ctrl.sv
// Scoreboard bench for jump_ctrl: directed vectors push expectations,
// a negedge monitor pops and compares the presented outputs.
module tb_jump_ctrl;
  logic clk;
  logic rst;

  jump_ctrl_if #(.AW(8), .OPW(7), .DEPTH(4)) bus ();

  jump_ctrl #(
    .AW(8), .OPW(7), .DEPTH(4), .LAST_ADDR(91)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic       l;
    logic [7:0] d;
    logic [2:0] sp;
    logic [3:0] fl;
    logic       ovf;
    logic       unf;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int fails  = 0;
  int vid    = 0;

  localparam logic [6:0] NOP  = 7'h00;
  localparam logic [6:0] JMP  = 7'h13;
  localparam logic [6:0] JEQ  = 7'h14;
  localparam logic [6:0] JNE  = 7'h15;
  localparam logic [6:0] JGT  = 7'h16;
  localparam logic [6:0] JLT  = 7'h17;
  localparam logic [6:0] JGE  = 7'h18;
  localparam logic [6:0] JLE  = 7'h19;
  localparam logic [6:0] JCR  = 7'h1A;
  localparam logic [6:0] JOV  = 7'h1B;
  localparam logic [6:0] CALL = 7'h1C;
  localparam logic [6:0] RET  = 7'h1D;

  task automatic chk(input int id, input string nm,
                     input logic [7:0] act,
                     input logic [7:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL v%0d.%s got %0d want %0d",
               id, nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.id, "l",      8'(bus.l),       8'(e.l));
      chk(e.id, "dataIM", bus.dataIM,      e.d);
      chk(e.id, "sp",     8'(bus.sp),      8'(e.sp));
      chk(e.id, "flags",  8'(bus.flags),   8'(e.fl));
      chk(e.id, "ovf",    8'(bus.stk_ovf), 8'(e.ovf));
      chk(e.id, "unf",    8'(bus.stk_unf), 8'(e.unf));
    end
  end

  // fin = {z,n,c,v}
  task automatic step(
    input logic       r,
    input logic [7:0] p,
    input logic [6:0] op,
    input logic [7:0] lit,
    input logic       fwe,
    input logic [3:0] fin,
    input logic       el,
    input logic [7:0] ed,
    input logic [2:0] esp,
    input logic [3:0] efl,
    input logic       eo,
    input logic       eu
  );
    exp_t e;
    @(posedge clk);
    #1;
    rst         = r;
    bus.pcc     = p;
    bus.instr   = {op, lit};
    bus.flag_we = fwe;
    bus.z_in    = fin[3];
    bus.n_in    = fin[2];
    bus.c_in    = fin[1];
    bus.v_in    = fin[0];
    e = '{vid, el, ed, esp, efl, eo, eu};
    q.push_back(e);
    vid++;
  endtask

  initial begin
    rst         = 1'b1;
    bus.pcc     = '0;
    bus.instr   = '0;
    bus.flag_we = 1'b0;
    bus.z_in    = 1'b0;
    bus.n_in    = 1'b0;
    bus.c_in    = 1'b0;
    bus.v_in    = 1'b0;
    repeat (2) @(posedge clk);

    //   rst pcc op   lit fwe fin      l  d   sp fl       o  u
    step(1, 5,  JMP, 40, 0, 4'b0000, 0, 0,  0, 4'b0000, 0, 0);
    step(0, 5,  JMP, 40, 0, 4'b0000, 1, 40, 0, 4'b0000, 0, 0);
    step(0, 6,  JNE, 30, 1, 4'b1000, 1, 30, 0, 4'b0000, 0, 0);
    step(0, 7,  JEQ, 20, 0, 4'b0000, 1, 20, 0, 4'b1000, 0, 0);
    step(0, 8,  JNE, 30, 0, 4'b0000, 0, 0,  0, 4'b1000, 0, 0);
    step(0, 9,  JGT, 7,  1, 4'b0110, 0, 0,  0, 4'b1000, 0, 0);
    step(0, 9,  JLT, 9,  0, 4'b0000, 1, 9,  0, 4'b0110, 0, 0);
    step(0, 9,  JGE, 9,  0, 4'b0000, 0, 0,  0, 4'b0110, 0, 0);
    step(0, 9,  JLE, 12, 0, 4'b0000, 1, 12, 0, 4'b0110, 0, 0);
    step(0, 9,  JCR, 13, 0, 4'b0000, 1, 13, 0, 4'b0110, 0, 0);
    step(0, 9,  JOV, 14, 0, 4'b0000, 0, 0,  0, 4'b0110, 0, 0);
    step(0, 9,  7'h20, 55, 0, 4'b0000, 0, 0, 0, 4'b0110, 0, 0);
    // call / return
    step(0, 10, CALL, 50, 0, 4'b0000, 1, 50, 0, 4'b0110, 0, 0);
    step(0, 50, NOP,  0,  0, 4'b0000, 0, 0,  1, 4'b0110, 0, 0);
    step(0, 51, RET,  0,  0, 4'b0000, 1, 11, 1, 4'b0110, 0, 0);
    step(0, 11, NOP,  0,  0, 4'b0000, 0, 0,  0, 4'b0110, 0, 0);
    // five calls into a 4-deep stack
    step(0, 20, CALL, 60, 0, 4'b0000, 1, 60, 0, 4'b0110, 0, 0);
    step(0, 21, CALL, 61, 0, 4'b0000, 1, 61, 1, 4'b0110, 0, 0);
    step(0, 22, CALL, 62, 0, 4'b0000, 1, 62, 2, 4'b0110, 0, 0);
    step(0, 23, CALL, 63, 0, 4'b0000, 1, 63, 3, 4'b0110, 0, 0);
    step(0, 24, CALL, 64, 0, 4'b0000, 1, 64, 4, 4'b0110, 0, 0);
    step(0, 30, RET,  0,  0, 4'b0000, 1, 24, 4, 4'b0110, 1, 0);
    step(0, 30, RET,  0,  0, 4'b0000, 1, 23, 3, 4'b0110, 1, 0);
    step(0, 30, RET,  0,  0, 4'b0000, 1, 22, 2, 4'b0110, 1, 0);
    step(0, 30, RET,  0,  0, 4'b0000, 1, 21, 1, 4'b0110, 1, 0);
    // underflow
    step(0, 30, RET,  0,  0, 4'b0000, 0, 0,  0, 4'b0110, 1, 0);
    step(0, 31, NOP,  0,  0, 4'b0000, 0, 0,  0, 4'b0110, 1, 1);
    // last address masking, flags still written
    step(0, 91, JMP,  3,  0, 4'b0000, 0, 0,  0, 4'b0110, 1, 1);
    step(0, 91, CALL, 8,  1, 4'b0001, 0, 0,  0, 4'b0110, 1, 1);
    step(0, 40, JOV,  77, 0, 4'b0000, 1, 77, 0, 4'b0001, 1, 1);
    step(0, 2,  CALL, 10, 0, 4'b0000, 1, 10, 0, 4'b0001, 1, 1);
    step(0, 10, CALL, 20, 0, 4'b0000, 1, 20, 1, 4'b0001, 1, 1);
    // reset mid-program with sp=2
    step(1, 20, CALL, 5,  1, 4'b1000, 0, 0,  2, 4'b0001, 1, 1);
    step(0, 21, NOP,  0,  0, 4'b0000, 0, 0,  0, 4'b0000, 0, 0);
    step(0, 22, RET,  0,  0, 4'b0000, 0, 0,  0, 4'b0000, 0, 0);
    step(0, 23, NOP,  0,  0, 4'b0000, 0, 0,  0, 4'b0000, 0, 1);

    for (int i = 0; i < 10 && q.size() != 0; i++)
      @(posedge clk);
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end
endmodule
